// File: rtl/sme_pkg.sv
// Shared definitions for the SME framing front end and the SME itself:
// feeder state encoding, default buffer depths, record kinds and the
// metacharacter byte codes understood by the matcher.
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_REPORT
  } sme_state_e;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  // in_kind encoding on the record stream
  localparam logic KIND_STR = 1'b0;
  localparam logic KIND_PAT = 1'b1;

  // pattern metacharacters
  localparam logic [7:0] META_BOL   = 8'h5E;  // '^'
  localparam logic [7:0] META_EOL   = 8'h24;  // '$'
  localparam logic [7:0] META_ANY   = 8'h2E;  // '.'
  localparam logic [7:0] META_STAR  = 8'h2A;  // '*'
  localparam logic [7:0] META_SPACE = 8'h20;  // ' '

  // a match index is only meaningful when the match flag is set
  function automatic logic [5:0] mask_index(input logic m, input logic [5:0] idx);
    return m ? idx : 6'd0;
  endfunction

endpackage

// File: rtl/sme_byte_buf.sv
// DEPTH x 8 record buffer. Bytes are appended at a write pointer; the
// record's length is latched on its last byte and saturates at DEPTH.
// Bytes past DEPTH are discarded and raise a sticky overflow flag that
// the owner clears once the job's result has been delivered.
module sme_byte_buf #(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr,
  input  logic [7:0]    i_data,
  input  logic          i_last,
  input  logic          i_clr,
  input  logic          i_clr_ovf,
  input  logic [LW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data,
  output logic [LW-1:0] o_len,
  output logic          o_ovf
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DEPTH-1:0][7:0] r_mem;
  logic [LW-1:0]         r_wptr;
  logic [LW-1:0]         r_len;
  logic                  r_ovf;
  logic                  w_full;

  assign w_full = (r_wptr == DEPTH_L);

  // storage is not reset; only the pointer/length/flag define contents
  always_ff @(posedge clk) begin
    if (i_wr && !w_full) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // write pointer, latched length and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_clr) begin
        r_wptr <= '0;
        r_len  <= '0;
      end
      if (i_wr) begin
        if (w_full) r_ovf <= 1'b1;
        if (i_last) begin
          r_len  <= w_full ? DEPTH_L : r_wptr + LW'(1);
          r_wptr <= '0;
        end else if (!w_full) begin
          r_wptr <= r_wptr + LW'(1);
        end
      end
      if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign o_rd_data = (i_rd_idx < DEPTH_L) ? r_mem[i_rd_idx[AW-1:0]] : 8'd0;
  assign o_len     = r_len;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/sme_frame_feeder.sv
// Framing stage in front of the string-matching engine. Buffers tagged
// string/pattern records, bursts string (when changed) then pattern to
// the SME without gaps, waits for the SME result and hands it downstream
// over a valid/ready beat.
// Optional: define SME_FEED_TIMEOUT_EN to add a watchdog on the WAIT
// state that forces an error result after TIMEOUT_CYCLES.
module sme_frame_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX        = STR_MAX_DEF,
  parameter int PAT_MAX        = PAT_MAX_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [5:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [5:0] res_index,
  output logic       res_err
);

  localparam int SLW = $clog2(STR_MAX) + 1;
  localparam int PLW = $clog2(PAT_MAX) + 1;

  sme_state_e     r_state, w_next;
  logic           w_acc, w_kind, w_wr_s, w_wr_p, w_end_s;
  logic           w_str_last, w_pat_last, w_res_hs, w_tmo_fire;
  logic [SLW-1:0] r_rd_s, w_str_len;
  logic [PLW-1:0] r_rd_p, w_pat_len;
  logic [7:0]     w_str_byte, w_pat_byte, r_char_hold;
  logic           w_ovf_s, w_ovf_p;
  logic           r_kind, r_str_dirty;
  logic           r_res_match, r_res_err;
  logic [5:0]     r_res_index;

  // first byte of a record (accepted in IDLE) fixes the record kind
  assign w_acc      = in_valid & in_ready;
  assign w_kind     = (r_state == ST_IDLE) ? in_kind : r_kind;
  assign w_wr_s     = w_acc & (w_kind == KIND_STR);
  assign w_wr_p     = w_acc & (w_kind == KIND_PAT);
  assign w_end_s    = w_wr_s & in_last;
  assign w_str_last = ((r_rd_s + SLW'(1)) == w_str_len);
  assign w_pat_last = ((r_rd_p + PLW'(1)) == w_pat_len);
  assign w_res_hs   = (r_state == ST_REPORT) & res_ready;

`ifdef SME_FEED_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYCLES);
  logic [WDW-1:0] r_wd;

  // counts cycles spent in WAIT; a late sme_valid still beats expiry
  always_ff @(posedge clk) begin
    if (reset || r_state != ST_WAIT) r_wd <= '0;
    else                             r_wd <= r_wd + WDW'(1);
  end

  assign w_tmo_fire = (r_state == ST_WAIT) && !sme_valid && (r_wd == WD_LIM);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_fire   = 1'b0;
`endif

  sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (w_wr_s),
    .i_data    (in_data),
    .i_last    (in_last),
    .i_clr     (1'b0),
    .i_clr_ovf (w_res_hs),
    .i_rd_idx  (r_rd_s),
    .o_rd_data (w_str_byte),
    .o_len     (w_str_len),
    .o_ovf     (w_ovf_s)
  );

  sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (w_wr_p),
    .i_data    (in_data),
    .i_last    (in_last),
    .i_clr     (w_res_hs),
    .i_clr_ovf (w_res_hs),
    .i_rd_idx  (r_rd_p),
    .o_rd_data (w_pat_byte),
    .o_len     (w_pat_len),
    .o_ovf     (w_ovf_p)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state: collect records, burst on pattern end, wait, report
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (w_acc) begin
          if (!in_last)                 w_next = ST_COLLECT;
          else if (w_kind == KIND_PAT)  w_next = r_str_dirty ? ST_SEND_STR : ST_SEND_PAT;
          else                          w_next = ST_IDLE;
        end
      end
      ST_SEND_STR: if (w_str_last) w_next = ST_SEND_PAT;
      ST_SEND_PAT: if (w_pat_last) w_next = ST_WAIT;
      ST_WAIT:     if (sme_valid || w_tmo_fire) w_next = ST_REPORT;
      ST_REPORT:   if (res_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // outputs: strobes straight from state so a reset drops them at once
  always_comb begin
    in_ready  = 1'b0;
    isstring  = 1'b0;
    ispattern = 1'b0;
    res_valid = 1'b0;
    chardata  = r_char_hold;
    case (r_state)
      ST_IDLE, ST_COLLECT: in_ready = 1'b1;
      ST_SEND_STR: begin
        isstring = 1'b1;
        chardata = w_str_byte;
      end
      ST_SEND_PAT: begin
        ispattern = 1'b1;
        chardata  = w_pat_byte;
      end
      ST_REPORT: res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign res_err   = r_res_err;

  // datapath: record kind, dirty flag, burst pointers, held byte, result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind      <= KIND_STR;
      r_str_dirty <= 1'b0;
      r_rd_s      <= '0;
      r_rd_p      <= '0;
      r_char_hold <= 8'd0;
      r_res_match <= 1'b0;
      r_res_index <= 6'd0;
      r_res_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_acc) r_kind <= in_kind;

      if (w_end_s)                                  r_str_dirty <= 1'b1;
      else if (r_state == ST_SEND_STR && w_str_last) r_str_dirty <= 1'b0;

      if (r_state == ST_SEND_STR) r_rd_s <= w_str_last ? '0 : r_rd_s + SLW'(1);
      if (r_state == ST_SEND_PAT) r_rd_p <= w_pat_last ? '0 : r_rd_p + PLW'(1);

      if (isstring || ispattern) r_char_hold <= chardata;

      if (r_state == ST_WAIT) begin
        if (sme_valid) begin
          r_res_match <= sme_match;
          r_res_index <= mask_index(sme_match, sme_match_index);
          r_res_err   <= w_ovf_s | w_ovf_p;
        end else if (w_tmo_fire) begin
          r_res_match <= 1'b0;
          r_res_index <= 6'd0;
          r_res_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_frame_feeder.sv
// Directed bench for sme_frame_feeder: record loading, gapless bursts,
// string reuse, overflow, backpressured results, reset mid-burst and
// (with SME_FEED_TIMEOUT_EN) the WAIT watchdog.
module tb_sme_frame_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_kind, in_last;
  logic [7:0] in_data, chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [5:0] sme_match_index, res_index;
  logic       res_valid, res_ready, res_match, res_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_p[$];

  sme_frame_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT_CYCLES(20)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_kind         (in_kind),
    .in_last         (in_last),
    .chardata        (chardata),
    .isstring        (isstring),
    .ispattern       (ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_match       (res_match),
    .res_index       (res_index),
    .res_err         (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one byte offered for exactly one rising edge, from negedge to negedge
  task automatic put(input logic [7:0] d, input logic k, input logic l);
    in_valid = 1'b1; in_data = d; in_kind = k; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_rec(input string s, input logic k, input logic gap);
    if (k) q_p.delete(); else q_s.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (k) q_p.push_back(s[i]); else q_s.push_back(s[i]);
      put(s[i], k, i == s.len() - 1);
      if (gap && i != s.len() - 1) @(negedge clk);
    end
  endtask

  // called on the first burst cycle; leaves on the first WAIT cycle
  task automatic burst(input int ns, input int np);
    chk("burst_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < ns; i++) begin
      chk("burst_str", 32'({isstring, ispattern, chardata}), 32'({2'b10, q_s[i]}));
      @(negedge clk);
    end
    for (int i = 0; i < np; i++) begin
      chk("burst_pat", 32'({isstring, ispattern, chardata}), 32'({2'b01, q_p[i]}));
      @(negedge clk);
    end
    chk("burst_end_hold", 32'({isstring, ispattern, chardata}), 32'({2'b00, q_p[np-1]}));
  endtask

  task automatic reply(input logic m, input logic [5:0] idx, input logic em,
                       input logic [5:0] eidx, input logic eerr, input int hold);
    if (hold > 0) res_ready = 1'b0;
    @(negedge clk);
    sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
    @(negedge clk);
    sme_valid = 1'b0;
    chk("res_valid_rise", 32'(res_valid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      chk("res_hold", 32'({res_valid, in_ready, res_match, res_err, res_index}),
          32'({1'b1, 1'b0, em, eerr, eidx}));
      @(negedge clk);
    end
    res_ready = 1'b1;
    chk("res_beat", 32'({res_match, res_index, res_err}), 32'({em, eidx, eerr}));
    @(negedge clk);
    chk("res_done", 32'({res_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic [7:0] d;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_kind = 1'b0; in_last = 1'b0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 6'd0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_strobes", 32'({isstring, ispattern, chardata}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_res", 32'({res_valid, res_match, res_index, res_err}), 32'd0);

    // stray SME result outside WAIT is ignored
    sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 6'd9;
    @(negedge clk);
    sme_valid = 1'b0;
    @(negedge clk);
    chk("stray_sme_valid", 32'({res_valid, res_match, in_ready}), 32'b001);

    // string "ab cd", pattern "cd": 5 string bytes, 2 pattern bytes
    send_rec("ab cd", 1'b0, 1'b0);
    send_rec("cd", 1'b1, 1'b0);
    burst(5, 2);
    reply(1'b1, 6'd3, 1'b1, 6'd3, 1'b0, 0);

    // string unchanged: pattern only, index masked on no-match
    send_rec("^x", 1'b1, 1'b0);
    burst(0, 2);
    reply(1'b0, 6'd5, 1'b0, 6'd0, 1'b0, 0);

    // 40-byte string overflows to 32 bytes and flags the job
    q_s.delete();
    for (int i = 0; i < 40; i++) begin
      d = 8'(48 + i);
      if (i < 32) q_s.push_back(d);
      put(d, 1'b0, i == 39);
    end
    send_rec("a", 1'b1, 1'b0);
    burst(32, 1);
    reply(1'b1, 6'd7, 1'b1, 6'd7, 1'b1, 0);
    send_rec("a", 1'b1, 1'b0);
    burst(0, 1);
    reply(1'b1, 6'd2, 1'b1, 6'd2, 1'b0, 0);

    // gapped input still produces a gapless burst
    send_rec("wxyz", 1'b0, 1'b1);
    send_rec("yz", 1'b1, 1'b1);
    burst(4, 2);
    reply(1'b1, 6'd2, 1'b1, 6'd2, 1'b0, 0);

    // result held for 10 cycles with res_ready low
    send_rec("q", 1'b1, 1'b0);
    burst(0, 1);
    reply(1'b1, 6'd1, 1'b1, 6'd1, 1'b0, 10);

    // kind of the first byte governs the record
    q_p.delete(); q_p.push_back(8'h7A); q_p.push_back(8'h7B);
    put(8'h7A, 1'b1, 1'b0);
    put(8'h7B, 1'b0, 1'b1);
    burst(0, 2);
    reply(1'b1, 6'd1, 1'b1, 6'd1, 1'b0, 0);

    // 10-byte pattern truncated to 8 and flagged
    send_rec("0123456789", 1'b1, 1'b0);
    burst(0, 8);
    reply(1'b0, 6'd9, 1'b0, 6'd0, 1'b1, 0);

`ifdef SME_FEED_TIMEOUT_EN
    // silent SME: forced error result 21 cycles after entering WAIT
    send_rec("t", 1'b1, 1'b0);
    burst(0, 1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'd21);
    chk("tmo_beat", 32'({res_match, res_index, res_err}), 32'({1'b0, 6'd0, 1'b1}));
    @(negedge clk);
    chk("tmo_done", 32'({res_valid, in_ready}), 32'b01);
`endif

    // reset during SEND_STR drops strobes and forgets the string
    send_rec("hello", 1'b0, 1'b0);
    send_rec("l", 1'b1, 1'b0);
    chk("pre_rst_burst", 32'({isstring, ispattern, chardata}), 32'({2'b10, 8'h68}));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", 32'({isstring, ispattern, chardata, in_ready}), 32'({2'b00, 8'h00, 1'b1}));
    reset = 1'b0;
    send_rec("e", 1'b1, 1'b0);
    burst(0, 1);
    reply(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
